// File: rtl/imem_loader_if.sv
// Host byte stream in, instruction-memory write port and session status out.
// The master side belongs to the host, the slave side to the loader.
interface imem_loader_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   start;
  logic                   in_valid;
  logic [7:0]             in_byte;
  logic                   in_last;
  logic                   in_ready;
  logic                   we;
  logic [31:0]            wa;
  logic [INS_W-1:0]       wd;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [INS_ADDRESS-2:0] word_count;

  modport master (
    output start, in_valid, in_byte, in_last,
    input  in_ready, we, wa, wd, busy, done, overflow, word_count
  );

  modport slave (
    input  start, in_valid, in_byte, in_last,
    output in_ready, we, wa, wd, busy, done, overflow, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into INS_W-bit words and writes them into
// instruction memory from address 0 upward, stopping writes once memory is full.
module imem_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam int BPW = INS_W / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WIW = INS_ADDRESS - 2;
  localparam int WCW = INS_ADDRESS - 1;
  localparam logic [WIW-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_OVF, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [INS_W-1:0] pack_q, pack_d;
  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [WIW-1:0]   word_idx_q, word_idx_d;
  logic [WCW-1:0]   word_count_q, word_count_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      wa_q, wa_d;
  logic [INS_W-1:0] wd_q, wd_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pack_q       <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      word_count_q <= '0;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      pack_q       <= pack_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pack_d       = pack_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    wa_d         = wa_q;
    wd_d         = wd_q;
    accept       = bus.in_valid && (state_q == S_LOAD || state_q == S_OVF);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          pack_d       = '0;
          byte_idx_d   = '0;
          word_idx_d   = '0;
          word_count_d = '0;
          last_d       = 1'b0;
          ovf_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          pack_d[8*byte_idx_q +: 8] = bus.in_byte;
          if (byte_idx_q == BIW'(BPW - 1) || bus.in_last) begin
            // Address and data are registered here so they hold after the write.
            state_d = S_WRITE;
            last_d  = bus.in_last;
            wa_d    = {{(32 - INS_ADDRESS){1'b0}}, word_idx_q, 2'b00};
            wd_d    = pack_d;
          end else begin
            byte_idx_d = byte_idx_q + BIW'(1);
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + WCW'(1);
        pack_d       = '0;
        byte_idx_d   = '0;
        if (last_q) begin
          state_d = S_DONE;
        end else if (word_idx_q == LAST_WORD) begin
          state_d = S_OVF;
          ovf_d   = 1'b1;
        end else begin
          word_idx_d = word_idx_q + WIW'(1);
          state_d    = S_LOAD;
        end
      end
      S_OVF: begin
        if (accept && bus.in_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_LOAD) || (state_q == S_OVF);
  assign bus.we         = (state_q == S_WRITE);
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_OVF);
  assign bus.done       = (state_q == S_DONE);
  assign bus.overflow   = ovf_q;
  assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Streams directed and random byte sessions into imem_loader and checks every
// memory write and the session status against a queue-based packing model.
module tb_imem_loader;
  localparam int INS_ADDRESS = 9;
  localparam int INS_W       = 32;
  localparam int BPW         = INS_W / 8;
  localparam int DEPTH       = 1 << (INS_ADDRESS - 2);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();
  imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]       stream[$];
  logic [31:0]      exp_wa[$];
  logic [INS_W-1:0] exp_wd[$];
  int               exp_wc;
  bit               exp_ovf;
  int               wr_cnt;
  logic [31:0]      last_wa;
  logic [INS_W-1:0] last_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the stream split into BPW-byte words, zero-padded, capped at memory depth.
  task automatic build_expect();
    int words;
    int n;
    exp_wa.delete();
    exp_wd.delete();
    words = (stream.size() + BPW - 1) / BPW;
    n = (words > DEPTH) ? DEPTH : words;
    for (int w = 0; w < n; w++) begin
      logic [INS_W-1:0] v;
      v = '0;
      for (int b = 0; b < BPW; b++)
        if (w * BPW + b < stream.size()) v[8*b +: 8] = stream[w * BPW + b];
      exp_wa.push_back(32'(w * 4));
      exp_wd.push_back(v);
    end
    exp_ovf = (words > DEPTH);
    exp_wc  = n;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("done_busy_exclusive", {bus.done, bus.busy} == 2'b11, 1'b0);
      if (bus.we) begin
        wr_cnt++;
        last_wa = bus.wa;
        last_wd = bus.wd;
        check("in_ready_during_write", bus.in_ready, 1'b0);
        if (exp_wa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got wa=%0h wd=%0h expected no write", bus.wa, bus.wd);
        end else begin
          check("write_addr", bus.wa, exp_wa.pop_front());
          check("write_data", bus.wd, exp_wd.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_outputs",
          {bus.in_ready, bus.we, bus.wa, bus.wd, bus.busy, bus.done, bus.overflow, bus.word_count},
          '0);
  endtask

  task automatic start_session();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_status", {bus.busy, bus.done, bus.overflow, bus.in_ready}, 4'b1001);
    check("start_word_count", bus.word_count, 0);
    wr_cnt = 0;
  endtask

  task automatic send_stream(input bit use_last, input bit gaps, input bit poke_start);
    int i = 0;
    int budget = 0;
    while (i < stream.size()) begin
      @(negedge clk);
      budget++;
      if (budget > 5000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got %0d bytes accepted expected %0d", i, stream.size());
        break;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = stream[i];
        bus.in_last  = use_last && (i == stream.size() - 1);
        if (bus.in_ready) i++;
      end
      if (poke_start) bus.start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic end_session();
    int k = 0;
    while (!bus.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", bus.done, 1'b1);
    check("end_overflow", bus.overflow, exp_ovf);
    check("end_word_count", bus.word_count, exp_wc);
    check("writes_outstanding", exp_wa.size(), 0);
    check("end_idle_outputs", {bus.busy, bus.in_ready, bus.we}, 3'b000);
  endtask

  task automatic run_session(input bit gaps, input bit poke_start);
    start_session();
    build_expect();
    send_stream(1'b1, gaps, poke_start);
    end_session();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    stream = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_session(1'b0, 1'b0);
    check("t1_writes", wr_cnt, 1);
    check("t1_wa", last_wa, 32'h0);
    check("t1_wd", last_wd, 32'h00000513);
    check("t1_wc", bus.word_count, 1);

    stream = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    run_session(1'b0, 1'b0);
    check("t2_writes", wr_cnt, 2);
    check("t2_wa", last_wa, 32'h4);
    check("t2_wd", last_wd, 32'h00200113);

    stream = '{8'hAA, 8'hBB, 8'hCC};
    run_session(1'b0, 1'b0);
    check("t3_wd", last_wd, 32'h00CCBBAA);

    stream.delete();
    for (int i = 0; i < 516; i++) stream.push_back(8'(i * 7 + 3));
    run_session(1'b0, 1'b0);
    check("t4_writes", wr_cnt, 128);
    check("t4_last_wa", last_wa, 32'h1FC);
    check("t4_overflow", bus.overflow, 1'b1);
    check("t4_wc", bus.word_count, 128);

    start_session();
    exp_wa.delete();
    exp_wd.delete();
    stream = '{8'h55, 8'h66};
    send_stream(1'b0, 1'b0, 1'b0);
    do_reset();
    stream = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1'b0, 1'b0);
    check("t5_writes", wr_cnt, 1);
    check("t5_wd", last_wd, 32'h04030201);

    for (int s = 0; s < 8; s++) begin
      int len;
      len = (s == 5) ? int'($urandom_range(513, 520)) : int'($urandom_range(1, 40));
      stream.delete();
      for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
      run_session(1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000ns");
    $fatal(1);
  end
endmodule
